// File: rtl/req_capture_prio_4.sv
// Captures rising edges on four request lines into a sticky pending register and
// hands out the highest-priority pending line as a registered valid/ready code.
module req_capture_prio_4 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_in,
  input  logic             ready_in,
  input  logic             ovf_clr,
  output logic             valid_out,
  output logic [1:0]       code_out,
  output logic [3:0]       pending_out,
  output logic [3:0]       overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [3:0]       r_req_prev;
  logic             r_armed;
  logic [3:0]       r_pending;
  logic             r_valid;
  logic [1:0]       r_code;
  logic [3:0]       r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [3:0]       w_ev;
  logic             w_load;
  logic [3:0]       w_grant;
  logic [1:0]       w_grant_code;
  logic [3:0]       w_drop;
  logic [3:0]       w_pending_d;
  logic             w_valid_d;
  logic [1:0]       w_code_d;
  logic [3:0]       w_overflow_d;
  logic [2:0]       w_ndrop;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W+2:0] w_cnt_sum;
  logic [CNT_W-1:0] w_drop_cnt_d;

  // The first cycle after reset has no real history, so lines already high are
  // only recorded into req_prev, never treated as events.
  assign w_ev   = req_in & ~r_req_prev & {4{r_armed}};
  assign w_load = ~r_valid | ready_in;

  always_comb begin
    w_grant      = 4'b0000;
    w_grant_code = 2'd0;
    if (w_load) begin
      if (r_pending[3]) begin
        w_grant      = 4'b1000;
        w_grant_code = 2'd3;
      end else if (r_pending[2]) begin
        w_grant      = 4'b0100;
        w_grant_code = 2'd2;
      end else if (r_pending[1]) begin
        w_grant      = 4'b0010;
        w_grant_code = 2'd1;
      end else if (r_pending[0]) begin
        w_grant      = 4'b0001;
        w_grant_code = 2'd0;
      end
    end
  end

  // A new event always wins over the grant clear of the same line.
  always_comb begin
    w_drop      = 4'b0000;
    w_pending_d = r_pending;
    for (int i = 0; i < 4; i++) begin
      w_drop[i]      = w_ev[i] & r_pending[i] & ~w_grant[i];
      w_pending_d[i] = w_ev[i] | (r_pending[i] & ~w_grant[i]);
    end
  end

  always_comb begin
    w_valid_d = r_valid;
    w_code_d  = r_code;
    if (w_load) begin
      w_valid_d = |r_pending;
      if (|r_pending) begin
        w_code_d = w_grant_code;
      end
    end
  end

  always_comb begin
    w_ndrop      = {2'b00, w_drop[0]} + {2'b00, w_drop[1]} +
                   {2'b00, w_drop[2]} + {2'b00, w_drop[3]};
    w_cnt_base   = ovf_clr ? '0 : r_drop_cnt;
    w_overflow_d = (ovf_clr ? 4'b0000 : r_overflow) | w_drop;
    w_cnt_sum    = {3'b000, w_cnt_base} + {{CNT_W{1'b0}}, w_ndrop};
    if (w_cnt_sum > {3'b000, {CNT_W{1'b1}}}) begin
      w_drop_cnt_d = {CNT_W{1'b1}};
    end else begin
      w_drop_cnt_d = w_cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_prev <= 4'b0000;
      r_armed    <= 1'b0;
      r_pending  <= 4'b0000;
      r_valid    <= 1'b0;
      r_code     <= 2'd0;
      r_overflow <= 4'b0000;
      r_drop_cnt <= '0;
    end else begin
      r_req_prev <= req_in;
      r_armed    <= 1'b1;
      r_pending  <= w_pending_d;
      r_valid    <= w_valid_d;
      r_code     <= w_code_d;
      r_overflow <= w_overflow_d;
      r_drop_cnt <= w_drop_cnt_d;
    end
  end

  assign valid_out   = r_valid;
  assign code_out    = r_code;
  assign pending_out = r_pending;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_req_capture_prio_4.sv
// Directed bench: expected codes are queued as requests are driven and popped at
// every valid/ready transfer; state outputs are checked at fixed points.
module tb_req_capture_prio_4;

  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [3:0]       req_in;
  logic             ready_in;
  logic             ovf_clr;
  logic             valid_out;
  logic [1:0]       code_out;
  logic [3:0]       pending_out;
  logic [3:0]       overflow;
  logic [CNT_W-1:0] drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  req_capture_prio_4 #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .ready_in   (ready_in),
    .ovf_clr    (ovf_clr),
    .valid_out  (valid_out),
    .code_out   (code_out),
    .pending_out(pending_out),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfers happen at the next rising edge; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst && valid_out === 1'b1 && ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", {30'd0, code_out}, 32'hFFFF_FFFF);
      end else begin
        chk("code_transfer", {30'd0, code_out}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_in = 4'b0000; ready_in = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_pending", {28'd0, pending_out}, 32'd0);
    chk("rst_code", {30'd0, code_out}, 32'd0);
    chk("rst_drop", {30'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Single pulse on line 2.
    req_in = 4'b0100; ready_in = 1'b1; exp_q.push_back(2'd2);
    tick();
    chk("t1_pending", {28'd0, pending_out}, 32'h4);
    chk("t1_valid_early", {31'd0, valid_out}, 32'd0);
    req_in = 4'b0000;
    tick();
    chk("t1_valid", {31'd0, valid_out}, 32'd1);
    chk("t1_code", {30'd0, code_out}, 32'd2);
    chk("t1_pending_clr", {28'd0, pending_out}, 32'd0);
    tick();
    chk("t1_valid_fall", {31'd0, valid_out}, 32'd0);

    // Simultaneous rise on 1011.
    req_in = 4'b1011;
    exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    tick();
    chk("t2_pend0", {28'd0, pending_out}, 32'hB);
    tick();
    chk("t2_code3", {30'd0, code_out}, 32'd3);
    chk("t2_pend1", {28'd0, pending_out}, 32'h3);
    tick();
    chk("t2_code1", {30'd0, code_out}, 32'd1);
    chk("t2_pend2", {28'd0, pending_out}, 32'h1);
    tick();
    chk("t2_code0", {30'd0, code_out}, 32'd0);
    chk("t2_pend3", {28'd0, pending_out}, 32'h0);
    tick();
    chk("t2_idle", {31'd0, valid_out}, 32'd0);
    req_in = 4'b0000;
    tick();

    // Back-pressure with a drop on line 0.
    ready_in = 1'b0; req_in = 4'b1000; exp_q.push_back(2'd3);
    tick();
    req_in = 4'b0000;
    tick();
    chk("t3_valid", {31'd0, valid_out}, 32'd1);
    req_in = 4'b0001;
    tick();
    req_in = 4'b0000;
    tick();
    req_in = 4'b0001;
    tick();
    req_in = 4'b0000;
    chk("t3_hold_code", {30'd0, code_out}, 32'd3);
    chk("t3_hold_valid", {31'd0, valid_out}, 32'd1);
    chk("t3_overflow", {28'd0, overflow}, 32'h1);
    chk("t3_drop", {30'd0, drop_cnt}, 32'd1);
    exp_q.push_back(2'd0); ready_in = 1'b1;
    tick();
    chk("t3_code0", {30'd0, code_out}, 32'd0);
    tick();
    chk("t3_once", {31'd0, valid_out}, 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_overflow", {28'd0, overflow}, 32'd0);
    chk("clr_drop", {30'd0, drop_cnt}, 32'd0);

    // Event on line 2 in the cycle line 2 is granted.
    req_in = 4'b1100;
    exp_q.push_back(2'd3); exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    tick();
    req_in = 4'b0000;
    tick();
    chk("t4_code3", {30'd0, code_out}, 32'd3);
    req_in = 4'b0100;
    tick();
    req_in = 4'b0000;
    chk("t4_code2", {30'd0, code_out}, 32'd2);
    chk("t4_pend_kept", {28'd0, pending_out}, 32'h4);
    chk("t4_no_ovf", {28'd0, overflow}, 32'd0);
    tick();
    chk("t4_code2_again", {30'd0, code_out}, 32'd2);
    chk("t4_valid2", {31'd0, valid_out}, 32'd1);
    tick();
    chk("t4_idle", {31'd0, valid_out}, 32'd0);

    // Saturation of the 2-bit drop counter, then clear coincident with a drop.
    ready_in = 1'b0; req_in = 4'b1000; exp_q.push_back(2'd3);
    tick();
    req_in = 4'b0000;
    tick();
    for (int i = 0; i < 6; i++) begin
      req_in = 4'b0010;
      tick();
      req_in = 4'b0000;
      tick();
    end
    chk("t5_sat", {30'd0, drop_cnt}, 32'd3);
    chk("t5_ovf", {28'd0, overflow}, 32'h2);
    chk("t5_pend", {28'd0, pending_out}, 32'h2);
    req_in = 4'b0001;
    tick();
    req_in = 4'b0000;
    tick();
    req_in = 4'b0001; ovf_clr = 1'b1;
    tick();
    req_in = 4'b0000; ovf_clr = 1'b0;
    chk("t5_clr_ovf", {28'd0, overflow}, 32'h1);
    chk("t5_clr_drop", {30'd0, drop_cnt}, 32'd1);
    exp_q.push_back(2'd1); exp_q.push_back(2'd0); ready_in = 1'b1;
    tick();
    chk("t5_code1", {30'd0, code_out}, 32'd1);
    tick();
    chk("t5_code0", {30'd0, code_out}, 32'd0);
    tick();
    chk("t5_idle", {31'd0, valid_out}, 32'd0);

    // Asynchronous reset with a held code and pending lines.
    ready_in = 1'b0; req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    tick();
    req_in = 4'b0110;
    tick();
    chk("t6_pre_pend", {28'd0, pending_out}, 32'h6);
    chk("t6_pre_valid", {31'd0, valid_out}, 32'd1);
    req_in = 4'b0010;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", {31'd0, valid_out}, 32'd0);
    chk("t6_code", {30'd0, code_out}, 32'd0);
    chk("t6_pend", {28'd0, pending_out}, 32'd0);
    chk("t6_ovf", {28'd0, overflow}, 32'd0);
    chk("t6_drop", {30'd0, drop_cnt}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t6_no_event", {28'd0, pending_out}, 32'd0);
    chk("t6_no_valid", {31'd0, valid_out}, 32'd0);
    req_in = 4'b0000;
    tick();
    req_in = 4'b0010; ready_in = 1'b1; exp_q.push_back(2'd1);
    tick();
    chk("t6_new_event", {28'd0, pending_out}, 32'h2);
    tick();
    chk("t6_code1", {30'd0, code_out}, 32'd1);
    tick();
    chk("t6_idle", {31'd0, valid_out}, 32'd0);
    req_in = 4'b0000;
    tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
